// File: rtl/polynomial_encoder.sv
// NewHope-512 polynomial packer: 512 x 14-bit coefficients -> 896 little-endian bytes.
// Optional compile macro POLY_ENCODER_FREEZE_EN reduces each coefficient x < 2Q to x mod Q before packing.
module polynomial_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [8:0]  poly_addrb,
  input  logic [15:0] poly_dob,
  output logic        byte_we,
  output logic [9:0]  byte_addr,
  output logic [7:0]  byte_di
);

  typedef enum logic [3:0] {
    IDLE, PRIME, S0, S1, S2, S3, S4, S5, S6, FINAL
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        g_q, g_d;
  logic [8:0]        addrb_q, addrb_d;
  logic [9:0]        wr_cnt_q, wr_cnt_d;
  logic              we_q, we_d;
  logic [9:0]        baddr_q, baddr_d;
  logic [7:0]        bdi_q, bdi_d;
  logic              done_q, done_d;
  logic [3:0][13:0]  c_q, c_d;
  logic [3:0]        arrive;
  logic [7:0]        byte_val;
  logic              emit;

  logic [15:0] coef_full;
  logic [13:0] coef;
  logic        unused_coef_hi;

`ifdef POLY_ENCODER_FREEZE_EN
  localparam logic [15:0] Q = 16'd12289;
  assign coef_full = (poly_dob >= Q) ? (poly_dob - Q) : poly_dob;
`else
  assign coef_full = poly_dob;
`endif
  assign coef           = coef_full[13:0];
  assign unused_coef_hi = ^coef_full[15:14];

  // Hold registers keep each coefficient for the bytes formed after its arrival cycle.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hold
      assign c_d[gi] = arrive[gi] ? coef : c_q[gi];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    addrb_d  = addrb_q;
    wr_cnt_d = wr_cnt_q;
    arrive   = 4'b0000;
    byte_val = 8'd0;
    emit     = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PRIME;
          g_d      = 7'd0;
          addrb_d  = 9'd0;
          wr_cnt_d = 10'd0;
        end
      end
      PRIME: begin
        state_d = S0;
        addrb_d = 9'd1;
      end
      S0: begin
        state_d   = S1;
        arrive[0] = 1'b1;
        byte_val  = coef[7:0];
        emit      = 1'b1;
      end
      S1: begin
        state_d   = S2;
        arrive[1] = 1'b1;
        byte_val  = {coef[1:0], c_q[0][13:8]};
        addrb_d   = {g_q, 2'b10};
        emit      = 1'b1;
      end
      S2: begin
        state_d  = S3;
        byte_val = c_q[1][9:2];
        emit     = 1'b1;
      end
      S3: begin
        state_d   = S4;
        arrive[2] = 1'b1;
        byte_val  = {coef[3:0], c_q[1][13:10]};
        addrb_d   = {g_q, 2'b11};
        emit      = 1'b1;
      end
      S4: begin
        state_d  = S5;
        byte_val = c_q[2][11:4];
        emit     = 1'b1;
      end
      S5: begin
        state_d   = S6;
        arrive[3] = 1'b1;
        byte_val  = {coef[5:0], c_q[2][13:12]};
        if (g_q != 7'd127) begin
          addrb_d = {g_q + 7'd1, 2'b00};
        end
        emit = 1'b1;
      end
      S6: begin
        byte_val = c_q[3][13:6];
        emit     = 1'b1;
        if (g_q == 7'd127) begin
          state_d = FINAL;
          addrb_d = 9'd0;
          done_d  = 1'b1;
        end else begin
          state_d = S0;
          g_d     = g_q + 7'd1;
          addrb_d = {g_q + 7'd1, 2'b01};
        end
      end
      FINAL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Byte bus idles at zero so downstream RAM sees clean data when not writing.
    we_d    = emit;
    baddr_d = emit ? wr_cnt_q : 10'd0;
    bdi_d   = emit ? byte_val : 8'd0;
    if (emit) begin
      wr_cnt_d = wr_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      g_q      <= 7'd0;
      addrb_q  <= 9'd0;
      wr_cnt_q <= 10'd0;
      we_q     <= 1'b0;
      baddr_q  <= 10'd0;
      bdi_q    <= 8'd0;
      done_q   <= 1'b0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      addrb_q  <= addrb_d;
      wr_cnt_q <= wr_cnt_d;
      we_q     <= we_d;
      baddr_q  <= baddr_d;
      bdi_q    <= bdi_d;
      done_q   <= done_d;
      c_q      <= c_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign poly_addrb = addrb_q;
  assign byte_we    = we_q;
  assign byte_addr  = baddr_q;
  assign byte_di    = bdi_q;

endmodule

// File: tb/tb_polynomial_encoder.sv
// Scoreboard bench for polynomial_encoder: arithmetic packing model, cycle-exact write/busy/done
// expectations, and a decode round trip of every completed run.
`timescale 1ns/1ps
module tb_polynomial_encoder;
  localparam int Q  = 12289;
  localparam int NB = 896;
`ifdef POLY_ENCODER_FREEZE_EN
  localparam int MAXC = 2 * Q - 1;
`else
  localparam int MAXC = 16383;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, byte_we;
  logic [8:0]  poly_addrb;
  logic [15:0] poly_dob;
  logic [9:0]  byte_addr;
  logic [7:0]  byte_di;

  polynomial_encoder dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .poly_addrb(poly_addrb), .poly_dob(poly_dob),
    .byte_we(byte_we), .byte_addr(byte_addr), .byte_di(byte_di)
  );

  always #5 clk = ~clk;

  logic [15:0] coef_mem [512];
  always @(posedge clk) poly_dob <= coef_mem[poly_addrb];

  typedef struct { int cyc; int addr; int data; bit last; } wr_t;
  typedef struct { int lo; int hi; } win_t;

  wr_t        exp_q[$];
  win_t       bw_q[$];
  int         exp_b [NB];
  int         ref_c [512];
  logic [7:0] byte_mem [NB];
  logic [7:0] lit [7];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int frz(int x);
`ifdef POLY_ENCODER_FREEZE_EN
    return (x >= Q) ? x - Q : x;
`else
    return x;
`endif
  endfunction

  // Reference: four 14-bit fields concatenated into a 56-bit little-endian word per group.
  task automatic build_model();
    for (int i = 0; i < 512; i++) ref_c[i] = frz(int'(coef_mem[i])) & 16'h3FFF;
    for (int g = 0; g < 128; g++) begin
      longint v = 0;
      for (int j = 0; j < 4; j++) v = v | (longint'(ref_c[4*g+j]) << (14*j));
      for (int k = 0; k < 7; k++) exp_b[7*g+k] = int'((v >> (8*k)) & 64'hFF);
    end
  endtask

  task automatic push_run(input int t);
    wr_t  e;
    win_t w;
    for (int k = 0; k < NB; k++) begin
      e.cyc = t + 3 + k; e.addr = k; e.data = exp_b[k]; e.last = (k == NB-1);
      exp_q.push_back(e);
    end
    w.lo = t + 1; w.hi = t + 898;
    bw_q.push_back(w);
  endtask

  task automatic start_pulse(output int t);
    @(negedge clk); #1;
    t = cyc;
    start = 1'b1;
    push_run(t);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bw_q.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      $display("FAIL drain_timeout pending_writes=%0d required=0", exp_q.size());
      $fatal(1, "scoreboard never drained");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic fill_random(input int hi);
    for (int i = 0; i < 512; i++) coef_mem[i] = 16'($urandom_range(0, hi));
  endtask

  task automatic fill_zero();
    for (int i = 0; i < 512; i++) coef_mem[i] = 16'd0;
  endtask

  function automatic void decode_check();
    int bad = 0;
    int first = -1;
    for (int g = 0; g < 128; g++) begin
      longint v = 0;
      for (int k = 0; k < 7; k++) v = v | (longint'(byte_mem[7*g+k]) << (8*k));
      for (int j = 0; j < 4; j++) begin
        if (int'((v >> (14*j)) & 64'h3FFF) != ref_c[4*g+j]) begin
          bad++;
          if (first < 0) first = 4*g + j;
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL roundtrip mismatched_coefs=%0d first_index=%0d required=0", bad, first);
    end
  endfunction

  // Monitor: compares every cycle's outputs against the queued expectations.
  initial forever begin
    bit  exp_busy;
    bit  exp_done;
    wr_t e;
    @(negedge clk);
    exp_busy = 1'b0;
    exp_done = 1'b0;
    if (rst) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || byte_we !== 1'b0 || poly_addrb !== 9'd0 ||
          byte_addr !== 10'd0 || byte_di !== 8'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d busy=%b done=%b we=%b addrb=%0d addr=%0d di=%h required all 0",
                 cyc, busy, done, byte_we, poly_addrb, byte_addr, byte_di);
      end
    end else begin
      if (bw_q.size() > 0 && cyc >= bw_q[0].lo) exp_busy = 1'b1;
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b required=%b", cyc, busy, exp_busy);
      end
      if (bw_q.size() > 0 && cyc >= bw_q[0].hi) void'(bw_q.pop_front());

      if (byte_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write cyc=%0d addr=%0d di=%h required no write", cyc, byte_addr, byte_di);
        end else begin
          e = exp_q.pop_front();
          if (byte_addr < 10'(NB)) byte_mem[byte_addr] = byte_di;
          checks++;
          if (cyc != e.cyc || int'(byte_addr) != e.addr || int'(byte_di) != e.data) begin
            errors++;
            $display("FAIL write cyc=%0d addr=%0d di=%02h required cyc=%0d addr=%0d di=%02h",
                     cyc, byte_addr, byte_di, e.cyc, e.addr, e.data);
          end
          exp_done = e.last;
          if (e.last) decode_check();
        end
      end else begin
        checks++;
        if (byte_we !== 1'b0 || byte_addr !== 10'd0 || byte_di !== 8'd0) begin
          errors++;
          $display("FAIL idle_bus cyc=%0d we=%b addr=%0d di=%h required 0", cyc, byte_we, byte_addr, byte_di);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          checks++; errors++;
          $display("FAIL missing_write cyc=%0d got no write required addr=%0d", cyc, exp_q[0].addr);
          void'(exp_q.pop_front());
        end
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done cyc=%0d got=%b required=%b", cyc, done, exp_done);
      end
    end
  end

  initial begin
    int t;
    fill_zero();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // All-zero polynomial.
    build_model();
    start_pulse(t);
    wait_drain();
    $display("run zeros start=%0d", t);

    // Extreme group at both ends, checked against hand-packed bytes.
    fill_zero();
    coef_mem[0] = 16'h3FFF; coef_mem[2] = 16'h3FFF;
    coef_mem[508] = 16'h3FFF; coef_mem[510] = 16'h3FFF;
    build_model();
`ifdef POLY_ENCODER_FREEZE_EN
    lit = '{8'hFE, 8'h0F, 8'h00, 8'hE0, 8'hFF, 8'h00, 8'h00};
`else
    lit = '{8'hFF, 8'h3F, 8'h00, 8'hF0, 8'hFF, 8'h03, 8'h00};
`endif
    for (int k = 0; k < 7; k++) begin
      exp_b[k] = int'(lit[k]);
      exp_b[889+k] = int'(lit[k]);
    end
    start_pulse(t);
    wait_drain();
    $display("run edge_groups start=%0d", t);

    // Random coefficients below Q, then across the full input contract.
    fill_random(Q - 1);
    build_model();
    start_pulse(t);
    wait_drain();
    $display("run random_lt_q start=%0d", t);
    fill_random(MAXC);
    build_model();
    start_pulse(t);
    wait_drain();
    $display("run random_full start=%0d", t);

    // Reset in the middle of a run, then a clean full run.
    fill_random(Q - 1);
    build_model();
    start_pulse(t);
    while (cyc < t + 400) @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    bw_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    $display("run reset_abort start=%0d reset_cyc=%0d", t, t + 400);
    fill_random(Q - 1);
    build_model();
    start_pulse(t);
    wait_drain();
    $display("run after_reset start=%0d", t);

    // Coefficient just above Q.
    fill_zero();
    coef_mem[0] = 16'd12290;
    build_model();
`ifdef POLY_ENCODER_FREEZE_EN
    exp_b[0] = 8'h01; exp_b[1] = 8'h00;
`else
    exp_b[0] = 8'h02; exp_b[1] = 8'h30;
`endif
    start_pulse(t);
    wait_drain();
    $display("run q_plus_1 start=%0d", t);

    // start held for 2000 cycles: restarts only from IDLE, every 899 cycles.
    fill_random(Q - 1);
    build_model();
    @(negedge clk); #1;
    t = cyc;
    start = 1'b1;
    push_run(t);
    push_run(t + 899);
    push_run(t + 1798);
    repeat (2000) @(negedge clk);
    #1 start = 1'b0;
    wait_drain();
    $display("run held_start start=%0d", t);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
